// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO registers.
// It takes WIDTH shift-add or restoring steps on operand magnitudes, then applies a sign fixup.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [WIDTH-1:0]   opb_reg;
  logic               is_div_reg, neg_q_reg, neg_r_reg, dz_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               done_reg, dz_out_reg;

  logic               accept, signed_op, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
  logic [2*WIDTH-1:0] step_next, prod_fix;
  logic [WIDTH-1:0]   quot, rem;

  assign accept    = start && (state_reg == IDLE);
  assign signed_op = ~op[0];
  assign b_zero    = (b == '0);
  assign mag_a     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // p_reg is {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    add_sum   = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, (p_reg[0] ? opb_reg : {WIDTH{1'b0}})};
    rem_shift = {p_reg[2*WIDTH-1:WIDTH], p_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb_reg};
    step_next = {add_sum, p_reg[WIDTH-1:1]};
    if (is_div_reg) begin
      if (rem_diff[WIDTH])
        step_next = {rem_shift[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b0};
      else
        step_next = {rem_diff[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b1};
    end
  end

  assign prod_fix = neg_q_reg ? (~p_reg + 1'b1) : p_reg;
  assign quot     = p_reg[WIDTH-1:0];
  assign rem      = p_reg[2*WIDTH-1:WIDTH];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept && !op[2]) state_next = (op[1] && b_zero) ? FIN : RUN;
      RUN:  if (cnt_reg == LAST) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      p_reg      <= '0;
      opb_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
      dz_out_reg <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      dz_out_reg <= 1'b0;
      case (state_reg)
        IDLE: if (accept) begin
          case (op)
            OP_MTHI: hi_reg <= a;
            OP_MTLO: lo_reg <= a;
            OP_MULT, OP_MULTU: begin
              p_reg      <= {{WIDTH{1'b0}}, mag_b};
              opb_reg    <= mag_a;
              is_div_reg <= 1'b0;
              neg_q_reg  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r_reg  <= 1'b0;
              dz_reg     <= 1'b0;
              cnt_reg    <= '0;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor keeps the raw dividend so it can be returned in HI.
              p_reg      <= {{WIDTH{1'b0}}, (b_zero ? a : mag_a)};
              opb_reg    <= mag_b;
              is_div_reg <= 1'b1;
              neg_q_reg  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r_reg  <= signed_op && a[WIDTH-1];
              dz_reg     <= b_zero;
              cnt_reg    <= '0;
            end
            default: ;
          endcase
        end
        RUN: begin
          p_reg   <= step_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIN: begin
          done_reg   <= 1'b1;
          dz_out_reg <= dz_reg;
          if (dz_reg) begin
            hi_reg <= p_reg[WIDTH-1:0];
            lo_reg <= '1;
          end else if (is_div_reg) begin
            lo_reg <= neg_q_reg ? (~quot + 1'b1) : quot;
            hi_reg <= neg_r_reg ? (~rem + 1'b1) : rem;
          end else begin
            {hi_reg, lo_reg} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign div_by_zero = dz_out_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a countdown/arithmetic reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_mul_div_unit;

  logic        clk, rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: {div_by_zero, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] model_result(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, p;
    sa = {{32{ma[31]}}, ma};
    sb = {{32{mb[31]}}, mb};
    ua = {32'b0, ma};
    ub = {32'b0, mb};
    model_result = '0;
    case (mop)
      3'b000: begin p = sa * sb; model_result = {1'b0, p}; end
      3'b001: begin p = ua * ub; model_result = {1'b0, p}; end
      3'b010, 3'b011: begin
        if (mb == 0) model_result = {1'b1, ma, 32'hFFFFFFFF};
        else if (mop == 3'b010) begin
          sq = sa / sb; sr = sa % sb;
          model_result = {1'b0, sr[31:0], sq[31:0]};
        end else begin
          uq = ua / ub; ur = ua % ub;
          model_result = {1'b0, ur[31:0], uq[31:0]};
        end
      end
      default: model_result = '0;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  logic        m_done, m_dz, m_res_dz;
  int          m_cnt;
  logic [64:0] r_tmp;

  always @(posedge clk) begin
    m_done <= 1'b0;
    m_dz   <= 1'b0;
    if (rst) begin
      m_hi <= 0; m_lo <= 0; m_cnt <= 0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_hi <= m_res_hi; m_lo <= m_res_lo;
        m_done <= 1'b1; m_dz <= m_res_dz;
      end
    end else if (start) begin
      if (op == 3'b100) m_hi <= a;
      else if (op == 3'b101) m_lo <= a;
      else if (op[2] == 1'b0) begin
        r_tmp = model_result(op, a, b);
        m_res_dz <= r_tmp[64];
        m_res_hi <= r_tmp[63:32];
        m_res_lo <= r_tmp[31:0];
        m_cnt    <= r_tmp[64] ? 1 : 33;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy", {31'b0, busy}, {31'b0, (m_cnt > 0)});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dz});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb);
    start = 1; op = o; a = xa; b = xb;
    cycle();
    start = 0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int bc, output logic dz);
    lat = 0; bc = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy) bc++;
      cycle();
      lat++;
    end
    dz = div_by_zero;
  endtask

  int lat, bc, dones;
  logic dz;

  initial begin
    rst = 1; start = 0; op = 0; a = 0; b = 0;
    cycle(); cycle();
    checking = 1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    rst = 0;
    cycle();

    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc, dz);
    check("multu_lat", lat, 33);
    check("multu_busy_cycles", bc, 33);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    issue(3'b000, 32'hFFFFFFFD, 32'd7);
    wait_done(lat, bc, dz);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);
    issue(3'b001, 32'd2, 32'd3);
    wait_done(lat, bc, dz);
    check("b2b_lat", lat, 33);
    check("b2b_hi", hi, 32'd0);
    check("b2b_lo", lo, 32'd6);

    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, bc, dz);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    issue(3'b011, 32'd100, 32'd7);
    wait_done(lat, bc, dz);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bc, dz);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h0);
    check("div_ovf_flag", {31'b0, dz}, 32'h0);

    issue(3'b011, 32'd5, 32'd0);
    wait_done(lat, bc, dz);
    check("dz_lat", lat, 1);
    check("dz_busy_cycles", bc, 1);
    check("dz_flag", {31'b0, dz}, 32'h1);
    check("dz_hi", hi, 32'd5);
    check("dz_lo", lo, 32'hFFFFFFFF);
    cycle();

    issue(3'b100, 32'h12345678, 32'd0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_done", {31'b0, done}, 32'h0);
    check("mthi_busy", {31'b0, busy}, 32'h0);
    issue(3'b101, 32'h9ABCDEF0, 32'd0);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi_kept", hi, 32'h12345678);

    issue(3'b000, 32'd6, 32'hFFFFFFFB);
    cycle(); cycle(); cycle();
    start = 1; op = 3'b100; a = 32'hDEADBEEF;
    cycle();
    op = 3'b011; b = 32'd0;
    cycle();
    start = 0;
    wait_done(lat, bc, dz);
    check("ignored_start_lat", lat, 28);
    check("ignored_start_hi", hi, 32'hFFFFFFFF);
    check("ignored_start_lo", lo, 32'hFFFFFFE2);

    issue(3'b110, 32'h11111111, 32'h22222222);
    check("reserved_busy", {31'b0, busy}, 32'h0);
    cycle();
    check("reserved_done", {31'b0, done}, 32'h0);
    check("reserved_hi", hi, 32'hFFFFFFFF);
    check("reserved_lo", lo, 32'hFFFFFFE2);

    issue(3'b101, 32'd5, 32'd0);
    check("pre_abort_lo", lo, 32'd5);
    issue(3'b010, 32'd100, 32'd3);
    for (int i = 0; i < 10; i++) cycle();
    rst = 1;
    cycle();
    rst = 0;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      cycle();
    end
    check("abort_no_done", dones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
